// File: rtl/axis_ins_pkg.sv
// Shared types and keep/count helpers for the AXI-Stream header inserter.
// Helpers work on a 16-bit keep (largest supported beat) and callers
// size-cast to their own byte width.
package axis_ins_pkg;

  localparam int MAX_B = 16;
  localparam int CNT_W = 5;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [MAX_B-1:0] keep_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  // Number of set bits in a keep vector.
  function automatic cnt_t keep_to_count(input keep_t keep);
    cnt_t n;
    n = '0;
    for (int i = 0; i < MAX_B; i++) begin
      n = n + cnt_t'(keep[i]);
    end
    return n;
  endfunction

  // n ones packed at the low end.
  function automatic keep_t count_to_keep_low(input cnt_t n);
    logic [MAX_B:0] one;
    logic [MAX_B:0] t;
    one = {{MAX_B{1'b0}}, 1'b1};
    t   = (one << n) - one;
    return t[MAX_B-1:0];
  endfunction

  // n ones packed at the top of a b-byte beat.
  function automatic keep_t count_to_keep_high(input cnt_t n, input cnt_t b);
    return count_to_keep_low(n) << (b - n);
  endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Combinational byte merge: prepends the H carried bytes to the incoming beat,
// extracts the H bytes that spill into the next beat, and forms the tail beat.
module axis_byte_packer
  import axis_ins_pkg::*;
#(
  parameter int DATA_WD = 32
) (
  input  logic [DATA_WD-1:0]   carry_i,
  input  logic [DATA_WD-1:0]   data_i,
  input  logic [DATA_WD/8-1:0] keep_i,
  input  cnt_t                 hcnt_i,
  output logic [DATA_WD-1:0]   merged_o,
  output logic [DATA_WD-1:0]   carry_next_o,
  output logic [DATA_WD-1:0]   flush_o
);

  localparam int   B     = DATA_WD / 8;
  localparam cnt_t B_CNT = cnt_t'(B);

  logic [DATA_WD-1:0] data_m;
  logic [DATA_WD-1:0] low_mask;
  logic [CNT_W+2:0]   sh_dat;
  logic [CNT_W+2:0]   sh_hdr;

  // Invalid input bytes are forced to zero so they never leak into outputs.
  genvar gi;
  generate
    for (gi = 0; gi < B; gi++) begin : g_mask
      assign data_m[gi*8 +: 8] = data_i[gi*8 +: 8] & {8{keep_i[gi]}};
    end
  endgenerate

  // A shift equal to the full width yields zero, which covers H=0 and H=B.
  assign sh_dat   = {hcnt_i, 3'b000};
  assign sh_hdr   = {B_CNT - hcnt_i, 3'b000};
  assign low_mask = ~({DATA_WD{1'b1}} << sh_dat);

  assign merged_o     = (carry_i << sh_hdr) | (data_m >> sh_dat);
  assign carry_next_o = data_m & low_mask;
  assign flush_o      = carry_i << sh_hdr;

endmodule

// File: rtl/axis_insert_header_p.sv
// Inserts a 0..B byte header in front of an AXI-Stream packet, realigning
// the payload bytes behind it. Output beats are registered (one-cycle latency).
module axis_insert_header_p
  import axis_ins_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_insert,
  output logic                    ready_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert
);

  localparam int   B     = DATA_BYTE_WD;
  localparam cnt_t B_CNT = cnt_t'(B);

  state_e             state_q, state_d;
  logic [DATA_WD-1:0] carry_q, carry_d;
  cnt_t               hcnt_q, hcnt_d;
  cnt_t               fcnt_q, fcnt_d;
  logic               valid_out_q, valid_out_d;
  logic [DATA_WD-1:0] data_out_q, data_out_d;
  logic [B-1:0]       keep_out_q, keep_out_d;
  logic               last_out_q, last_out_d;

  logic               can_load;
  cnt_t               hdr_cnt;
  cnt_t               lin;
  cnt_t               room;
  logic [DATA_WD-1:0] hdr_mask;
  logic [DATA_WD-1:0] merged;
  logic [DATA_WD-1:0] carry_next;
  logic [DATA_WD-1:0] flush_data;

  axis_byte_packer #(.DATA_WD(DATA_WD)) u_packer (
    .carry_i      (carry_q),
    .data_i       (data_in),
    .keep_i       (keep_in),
    .hcnt_i       (hcnt_q),
    .merged_o     (merged),
    .carry_next_o (carry_next),
    .flush_o      (flush_data)
  );

  // Output slot is free when empty or being drained this cycle.
  assign can_load     = !valid_out_q || ready_out;
  assign ready_insert = rst_n && (state_q == IDLE);
  assign ready_in     = rst_n && ((state_q == HDR) || (state_q == STREAM)) && can_load;

  assign hdr_cnt  = keep_to_count(keep_t'(keep_insert));
  assign hdr_mask = ~({DATA_WD{1'b1}} << {hdr_cnt, 3'b000});
  assign lin      = keep_to_count(keep_t'(keep_in));
  assign room     = B_CNT - hcnt_q;

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;

  // Next-state and next-output-beat decode.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    hcnt_d      = hcnt_q;
    fcnt_d      = fcnt_q;
    valid_out_d = valid_out_q && !ready_out;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;
    case (state_q)
      IDLE: begin
        if (valid_insert && ready_insert) begin
          carry_d = header_insert & hdr_mask;
          hcnt_d  = hdr_cnt;
          state_d = HDR;
        end
      end
      HDR, STREAM: begin
        if (valid_in && ready_in) begin
          data_out_d  = merged;
          carry_d     = carry_next;
          valid_out_d = 1'b1;
          keep_out_d  = '1;
          last_out_d  = 1'b0;
          state_d     = STREAM;
          if (last_in) begin
            if (lin <= room) begin
              keep_out_d = B'(count_to_keep_high(hcnt_q + lin, B_CNT));
              last_out_d = 1'b1;
              state_d    = IDLE;
            end else begin
              // Tail bytes remain in the carry and go out in one extra beat.
              fcnt_d  = lin - room;
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (can_load) begin
          data_out_d  = flush_data;
          keep_out_d  = B'(count_to_keep_high(fcnt_q, B_CNT));
          last_out_d  = 1'b1;
          valid_out_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Carry and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q     <= '0;
      hcnt_q      <= '0;
      fcnt_q      <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
    end else begin
      carry_q     <= carry_d;
      hcnt_q      <= hcnt_d;
      fcnt_q      <= fcnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
    end
  end

endmodule

// File: tb/tb_axis_insert_header_p.sv
// Bench for axis_insert_header_p at DATA_WD=32: directed packets with known
// outputs, then 200 random packets under random backpressure against a
// byte-stream reference model.
module tb_axis_insert_header_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        valid_insert;
  logic        ready_insert;
  logic [31:0] header_insert;
  logic [3:0]  keep_insert;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  int    n_assert = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  bit    rand_ready = 1'b0;
  bit    stall_q = 1'b0;
  beat_t held;

  always #5 clk = ~clk;

  axis_insert_header_p #(.DATA_WD(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .ready_in      (ready_in),
    .data_in       (data_in),
    .keep_in       (keep_in),
    .last_in       (last_in),
    .valid_out     (valid_out),
    .ready_out     (ready_out),
    .data_out      (data_out),
    .keep_out      (keep_out),
    .last_out      (last_out),
    .valid_insert  (valid_insert),
    .ready_insert  (ready_insert),
    .header_insert (header_insert),
    .keep_insert   (keep_insert)
  );

  // Output sink backpressure.
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Collector: checks stall stability and compares each transferred beat.
  always @(negedge clk) begin
    beat_t obs;
    beat_t expb;
    obs = {data_out, keep_out, last_out};
    if (rst_n !== 1'b1) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        n_assert++;
        assert (valid_out === 1'b1 && obs === held) else begin
          n_fail++;
          $error("FAIL stall_hold: observed valid=%b beat=%h expected valid=1 beat=%h",
                 valid_out, obs, held);
        end
      end
      if (valid_out === 1'b1 && ready_out === 1'b1) begin
        n_assert++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL extra_beat: observed %h expected no beat", obs);
        end
        if (exp_q.size() > 0) begin
          expb = exp_q.pop_front();
          n_assert++;
          assert (obs === expb) else begin
            n_fail++;
            $error("FAIL out_beat: observed d=%h k=%b l=%b expected d=%h k=%b l=%b",
                   obs.d, obs.k, obs.l, expb.d, expb.k, expb.l);
          end
          $display("beat d=%h k=%b l=%b", obs.d, obs.k, obs.l);
        end
      end
      stall_q = (valid_out === 1'b1) && (ready_out !== 1'b1);
      held    = obs;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the header handshake.
  task automatic send_header(input logic [31:0] h, input logic [3:0] k);
    bit hs;
    int cyc;
    header_insert = h;
    keep_insert   = k;
    valid_insert  = 1'b1;
    hs  = 1'b0;
    cyc = 0;
    while (!hs && cyc < 100) begin
      @(negedge clk);
      hs = (ready_insert === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_insert = 1'b0;
    chk("hdr_handshake", 64'(hs), 64'd1);
  endtask

  // Leaves valid_in asserted so consecutive beats can go back to back.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit hs;
    int cyc;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    valid_in = 1'b1;
    hs  = 1'b0;
    cyc = 0;
    while (!hs && cyc < 100) begin
      @(negedge clk);
      hs = (ready_in === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("beat_handshake", 64'(hs), 64'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_out), 64'd0);
    chk({tag, "_data"}, 64'(data_out), 64'd0);
    chk({tag, "_keep"}, 64'(keep_out), 64'd0);
    chk({tag, "_last"}, 64'(last_out), 64'd0);
    chk({tag, "_rdy_in"}, 64'(ready_in), 64'd0);
    chk({tag, "_rdy_ins"}, 64'(ready_insert), 64'd0);
  endtask

  initial begin
    int    h, nb, lb;
    logic [31:0] hdr;
    logic [3:0]  ki;
    logic [31:0] d[4];
    logic [3:0]  k[4];
    logic [7:0]  bq[$];
    beat_t e;

    rst_n = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; header_insert = '0; keep_insert = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready_insert", 64'(ready_insert), 64'd1);

    // Two-byte header, three-beat packet, tail fits in the last beat.
    exp_q.push_back({32'hBBCC1122, 4'b1111, 1'b0});
    exp_q.push_back({32'h33445566, 4'b1111, 1'b0});
    exp_q.push_back({32'h778899AA, 4'b1111, 1'b1});
    send_header(32'hAAAABBCC, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    send_beat(32'h99AABBCC, 4'b1100, 1'b1);
    valid_in = 1'b0;
    drain();

    // Three-byte header, single full beat: needs a flush beat.
    exp_q.push_back({32'hDDEEFF11, 4'b1111, 1'b0});
    exp_q.push_back({32'h22334400, 4'b1110, 1'b1});
    send_header(32'h00DDEEFF, 4'b0111);
    send_beat(32'h11223344, 4'b1111, 1'b1);
    valid_in = 1'b0;
    @(negedge clk);
    chk("flush_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // One-byte header, one-byte payload; output one cycle after acceptance.
    exp_q.push_back({32'hAB110000, 4'b1100, 1'b1});
    send_header(32'h000000AB, 4'b0001);
    send_beat(32'h11223344, 4'b1000, 1'b1);
    valid_in = 1'b0;
    chk("latency_valid", 64'(valid_out), 64'd1);
    chk("latency_data", 64'(data_out), 64'hAB110000);
    drain();

    // Data without a header is never accepted.
    data_in = 32'hDEADBEEF; keep_in = 4'b1111; last_in = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready_in", 64'(ready_in), 64'd0);
    end
    @(posedge clk);
    #1 valid_in = 1'b0;

    // Empty header (pass-through) offered together with the first beat.
    exp_q.push_back({32'h01020304, 4'b1111, 1'b0});
    exp_q.push_back({32'h05060708, 4'b1111, 1'b0});
    exp_q.push_back({32'h090A0B00, 4'b1110, 1'b1});
    header_insert = 32'h5A5A5A5A; keep_insert = 4'b0000; valid_insert = 1'b1;
    data_in = 32'h01020304; keep_in = 4'b1111; last_in = 1'b0; valid_in = 1'b1;
    @(negedge clk);
    chk("concurrent_ready_in", 64'(ready_in), 64'd0);
    chk("concurrent_ready_insert", 64'(ready_insert), 64'd1);
    @(posedge clk);
    #1 valid_insert = 1'b0;
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b0);
    send_beat(32'h090A0B00, 4'b1110, 1'b1);
    valid_in = 1'b0;
    drain();

    // Reset in the middle of a packet, then a clean packet.
    exp_q.push_back({32'hBBCC1122, 4'b1111, 1'b0});
    send_header(32'hAAAABBCC, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    chk("midreset_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({32'hAB110000, 4'b1100, 1'b1});
    send_header(32'h000000AB, 4'b0001);
    send_beat(32'h11223344, 4'b1000, 1'b1);
    valid_in = 1'b0;
    drain();

    // Random packets under random backpressure, checked as a byte stream.
    void'($urandom(2));
    rand_ready = 1'b1;
    for (int p = 0; p < 200; p++) begin
      h   = $urandom_range(0, 4);
      ki  = 4'b0000;
      for (int i = 0; i < h; i++) ki[i] = 1'b1;
      hdr = $urandom;
      nb  = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        d[i] = $urandom;
        k[i] = 4'b1111;
      end
      lb = $urandom_range(1, 4);
      k[nb-1] = 4'b0000;
      for (int j = 0; j < lb; j++) k[nb-1][3-j] = 1'b1;

      // Reference: header bytes then payload bytes, MSB first, re-chunked.
      bq.delete();
      for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[i*8 +: 8]);
      for (int i = 0; i < nb; i++)
        for (int j = 3; j >= 0; j--)
          if (k[i][j]) bq.push_back(d[i][j*8 +: 8]);
      while (bq.size() > 0) begin
        e = '0;
        for (int j = 3; j >= 0; j--) begin
          if (bq.size() > 0) begin
            e.d[j*8 +: 8] = bq.pop_front();
            e.k[j] = 1'b1;
          end
        end
        e.l = (bq.size() == 0);
        exp_q.push_back(e);
      end

      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_header(hdr, ki);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          valid_in = 1'b0;
          @(posedge clk);
          #1;
        end
        send_beat(d[i], k[i], (i == nb - 1));
      end
      valid_in = 1'b0;
    end
    drain();
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
